// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the parametrised synchronous FIFO family.
//   - default WIDTH/DEPTH constants
//   - clog2 helper for pointer width derivation
//   - parameter-legality helpers (DEPTH power of two, level ranges)
// No ports; imported by sync_fifo_param and fifo_ram_dp.
// ----------------------------------------------------------------------------
package fifo_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 256;
    localparam int unsigned MIN_DEPTH     = 4;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic bit is_pow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

    // Levels are compared against usedw in 1..depth.
    function automatic bit level_ok(input int unsigned level, input int unsigned depth);
        return (level >= 1) && (level <= depth);
    endfunction

    function automatic bit params_ok(
        input int unsigned width,
        input int unsigned depth,
        input int unsigned af_level,
        input int unsigned ae_level
    );
        return (width >= 1) && (depth >= MIN_DEPTH) && is_pow2(depth)
            && level_ok(af_level, depth) && level_ok(ae_level, depth);
    endfunction

endpackage

// File: rtl/fifo_ram_dp.sv
// ----------------------------------------------------------------------------
// fifo_ram_dp
// WIDTH x DEPTH register-array dual-port memory used as FIFO storage.
// Synchronous write port, asynchronous (combinational) read port, so it maps
// to plain flops or to a distributed/inferred RAM.
// Ports:
//   clock  in   write clock, rising edge
//   wren   in   write enable
//   waddr  in   write address  [AW-1:0]
//   wdata  in   write data     [WIDTH-1:0]
//   raddr  in   read address   [AW-1:0]
//   rdata  out  read data      [WIDTH-1:0], combinational from raddr
// Storage has no reset; the FIFO never exposes an unwritten location.
// ----------------------------------------------------------------------------
module fifo_ram_dp
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    localparam int unsigned AW   = clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             wren,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wren) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// ----------------------------------------------------------------------------
// sync_fifo_param
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds, optional show-ahead read mode and sticky error flags.
// Parameters:
//   WIDTH      data word width (>= 1)
//   DEPTH      entries, power of two, >= 4
//   AF_LEVEL   almost_full  when usedw >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL   almost_empty when usedw <  AE_LEVEL (1..DEPTH)
//   SHOWAHEAD  0: q registered on accepted read; 1: head word shown on q
// Ports:
//   clock         in   sole clock, rising edge
//   aclr          in   asynchronous clear, active-high
//   sclr          in   synchronous clear, active-high, beats wrreq/rdreq
//   data          in   write data
//   wrreq/rdreq   in   write/read requests
//   q             out  read data
//   usedw         out  stored word count, 0..DEPTH
//   full, empty, almost_full, almost_empty   out  status flags
//   overflow, underflow                      out  sticky error flags
// ----------------------------------------------------------------------------
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned DEPTH     = DEFAULT_DEPTH,
    parameter int unsigned AF_LEVEL  = DEPTH - 4,
    parameter int unsigned AE_LEVEL  = 4,
    parameter bit          SHOWAHEAD = 1'b0,
    localparam int unsigned AW       = clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             aclr,
    input  logic             sclr,
    input  logic [WIDTH-1:0] data,
    input  logic             wrreq,
    input  logic             rdreq,
    output logic [WIDTH-1:0] q,
    output logic [AW:0]      usedw,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow
);

    // ------------------------------------------------------------------------
    // Elaboration-time legality check
    // ------------------------------------------------------------------------
    if (!params_ok(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_check
        $error("sync_fifo_param: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL combination");
    end

    localparam logic [AW:0]   USEDW_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   USEDW_MAX = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   AF_THRESH = (AW + 1)'(AF_LEVEL);
    localparam logic [AW:0]   AE_THRESH = (AW + 1)'(AE_LEVEL);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   usedw_q,  usedw_d;
    logic          overflow_q,  overflow_d;
    logic          underflow_q, underflow_d;

    logic             wr_ok;
    logic             rd_ok;
    logic             wr_reject;
    logic             rd_reject;
    logic             ram_wren;
    logic [WIDTH-1:0] ram_rdata;

    // ------------------------------------------------------------------------
    // Status flags, decoded from the registered count only
    // ------------------------------------------------------------------------
    always_comb begin
        full         = (usedw_q == USEDW_MAX);
        empty        = (usedw_q == '0);
        almost_full  = (usedw_q >= AF_THRESH);
        almost_empty = (usedw_q <  AE_THRESH);
    end

    assign usedw     = usedw_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // ------------------------------------------------------------------------
    // Acceptance on pre-edge state. When full, a simultaneous read does not
    // make room for the write in the same cycle (and vice versa when empty).
    // ------------------------------------------------------------------------
    always_comb begin
        wr_ok     = wrreq && !full;
        rd_ok     = rdreq && !empty;
        wr_reject = wrreq && full;
        rd_reject = rdreq && empty;
    end

    // sclr discards the cycle's requests, including the memory write.
    assign ram_wren = wr_ok && !sclr;

    // ------------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        usedw_d     = usedw_q;
        overflow_d  = overflow_q | wr_reject;
        underflow_d = underflow_q | rd_reject;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({wr_ok, rd_ok})
            2'b10:   usedw_d = usedw_q + USEDW_ONE;
            2'b01:   usedw_d = usedw_q - USEDW_ONE;
            default: usedw_d = usedw_q;
        endcase
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            usedw_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (sclr) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            usedw_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            usedw_q     <= usedw_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    fifo_ram_dp #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock (clock),
        .wren  (ram_wren),
        .waddr (wr_ptr_q),
        .wdata (data),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // ------------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------------
    if (SHOWAHEAD) begin : g_showahead
        // Head word presented combinationally; forced to 0 while empty so a
        // stale or unwritten location is never visible.
        always_comb begin
            q = empty ? '0 : ram_rdata;
        end
    end else begin : g_normal
        logic [WIDTH-1:0] q_q;

        always_ff @(posedge clock or posedge aclr) begin
            if (aclr) begin
                q_q <= '0;
            end else if (sclr) begin
                q_q <= '0;
            end else if (rd_ok) begin
                q_q <= ram_rdata;
            end
        end

        assign q = q_q;
    end

endmodule
